// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with runtime-loadable pattern/length/overlap.
// Optional saturating match counter is built only when SEQ_DET_COUNT_EN is defined.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter int                 MOORE       = 0,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1000),
  parameter int                 RST_LEN     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  output logic                         detect,
  output logic [CNT_W-1:0]             match_count
);

  localparam int               LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_LEN_L = (RST_LEN > MAX_LEN) ? MAX_LEN_L : LEN_W'(RST_LEN);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  // The newest history bit is din itself, so only MAX_LEN-1 older bits are stored.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W:0]     w_fill_p1;
  logic               w_len_ok;
  logic               w_match;
  logic [LEN_W-1:0]   w_cfg_len;

  assign w_accept    = din_valid && !cfg_load;
  assign w_hist_next = {r_hist, din};
  assign w_fill_p1   = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
  assign w_len_ok    = (r_len != '0) && (w_fill_p1 >= {1'b0, r_len});
  assign w_match     = w_accept && w_len_ok && (((w_hist_next ^ r_pat) & w_mask) == '0);
  assign w_cfg_len   = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat  <= RST_PATTERN;
      r_len  <= RST_LEN_L;
      r_ovl  <= 1'b1;
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= w_cfg_len;
      r_ovl  <= cfg_overlap;
      r_hist <= '0;
      r_fill <= '0;
    end else if (din_valid) begin
      r_hist <= w_hist_next[MAX_LEN-2:0];
      if (w_match && !r_ovl) begin
        r_fill <= '0;
      end else if (r_fill != MAX_LEN_L) begin
        r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

  generate
    if (MOORE != 0) begin : g_moore
      logic r_detect;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_detect <= 1'b0;
        end else begin
          r_detect <= w_match;
        end
      end
      assign detect = r_detect;
    end else begin : g_mealy
      assign detect = w_match;
    end
  endgenerate

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (cfg_load) begin
      r_count <= '0;
    end else if (w_match && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 Parameter MOORE, default 0: 0 selects a combinational (Mealy) detect output, 1 selects a registered (Moore) detect output.
REQ-004 Parameter RST_PATTERN, default 8'b0000_1000: pattern loaded at reset.
REQ-005 Parameter RST_LEN, default 4: pattern length loaded at reset.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port din, input, 1 bit: serial data bit.
REQ-009 Port din_valid, input, 1 bit: din is sampled only when this is high.
REQ-010 Port cfg_load, input, 1 bit: latches cfg_pattern, cfg_len and cfg_overlap on a rising clk edge.
REQ-011 Port cfg_pattern, input, MAX_LEN bits: target pattern; bit [len-1] is the first bit received, bit [0] is the last.
REQ-012 Port cfg_len, input, $clog2(MAX_LEN+1) bits: pattern length.
REQ-013 Port cfg_overlap, input, 1 bit: 1 allows overlapping matches, 0 makes matches non-overlapping.
REQ-014 Port detect, output, 1 bit: one-cycle pulse per match.
REQ-015 Port match_count, output, CNT_W bits: count of matches since reset or the last cfg_load.

Function
REQ-016 The block SHALL hold the following internal registers:
- pat_r, len_r, ovl_r: latched configuration.
- hist: MAX_LEN-bit shift register.
- fill: valid-bit counter, saturating at MAX_LEN.
REQ-017 On each accepted bit (din_valid=1, cfg_load=0), hist SHALL shift left with din entering bit 0, and fill SHALL increment, saturating at MAX_LEN.
REQ-018 A match SHALL occur on an accepted bit when all three hold:
- len_r is nonzero;
- fill+1 >= len_r;
- the low len_r bits of the post-shift history equal the low len_r bits of pat_r.
REQ-019 MOORE=0: detect SHALL equal the match condition combinationally in the same cycle as the accepted bit.
REQ-020 MOORE=1: detect SHALL be registered and go high for exactly one cycle after the clk edge that accepts the matching bit.
REQ-021 When ovl_r=0, a match SHALL clear fill to 0 so that no bit is shared between two matches; hist is unaffected.
REQ-022 When ovl_r=1, fill SHALL continue incrementing after a match.
REQ-023 Cycles with din_valid=0 SHALL change neither hist nor fill, and detect SHALL be 0 in such a cycle (MOORE=0).
REQ-024 cfg_len=0 SHALL disable detection; cfg_len>MAX_LEN SHALL be clamped to MAX_LEN when latched.
REQ-025 When cfg_load=1, the block SHALL latch the configuration, clear hist, fill and match_count, and discard the concurrent din.
REQ-026 When cfg_load=1, detect SHALL be 0 in that cycle (MOORE=0), and no detect SHALL result from that cycle (MOORE=1).
REQ-027 Patterns longer than the bits received so far SHALL never match, regardless of the contents of hist.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously set:
- pat_r=RST_PATTERN, len_r=RST_LEN, ovl_r=1;
- hist=0, fill=0;
- registered detect=0, match_count=0.
REQ-029 Reset asserted mid-sequence SHALL discard all partial history; the first bit accepted after release counts as bit 1.

Configuration
REQ-030 Macro SEQ_DET_COUNT_EN defined: match_count SHALL increment by 1 on each match and saturate at 2^CNT_W-1.
REQ-031 Macro SEQ_DET_COUNT_EN undefined: no counter logic SHALL be built, and match_count SHALL be tied to 0.

Verification
REQ-032 Reset defaults, MOORE=0, din_valid=1, stream 1,0,0,0 -> detect=1 in the 4th-bit cycle only; match_count=1 (SEQ_DET_COUNT_EN).
REQ-033 Load pattern 3'b101, len 3, overlap=1, stream 1,0,1,0,1 -> detect on bits 3 and 5; repeat with overlap=0 -> detect on bit 3 only.
REQ-034 Same stream as REQ-032 with din_valid=0 gaps of 2 cycles between bits -> a single detect on the 4th valid bit; no detect in gap cycles.
REQ-035 Stream 1,0,0, then cfg_load (pattern 4'b1000, len 4) together with din=0, then 0 -> no detect; match_count=0.
REQ-036 MOORE=1 with the REQ-032 stream -> detect high exactly one cycle after the 4th-bit edge.
REQ-037 CNT_W=2, SEQ_DET_COUNT_EN defined, 5 matches -> match_count=3; cfg_len=0 with any stream -> detect stays 0.
